// File: rtl/psum_stream_accumulator_pkg.sv
// Shared sizing helpers for the partial-sum datapath (also used by adder_tree).
package psum_stream_accumulator_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Width needed to hold acc_count unsigned in_width-bit values without wrapping.
  function automatic int acc_width(input int in_width, input int acc_count);
    return in_width + clog2(acc_count);
  endfunction

  // Counter width for a 0..n-1 counter, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/psum_stream_accumulator_requant_sat.sv
// Combinational requantiser: optional round-half-up, right shift, unsigned saturate.
module requant_sat #(
  parameter int ACC_W     = 20,
  parameter int SHIFT     = 8,
  parameter int ROUND     = 1,
  parameter int OUT_WIDTH = 8
) (
  input  logic [ACC_W-1:0]     sum,
  output logic [OUT_WIDTH-1:0] pix,
  output logic                 sat
);

  // Internal width: one guard bit above ACC_W so sum + rounding constant never
  // wraps, widened further if the output is wider than that.
  localparam int QW = ((ACC_W + 1) > OUT_WIDTH) ? (ACC_W + 1) : OUT_WIDTH;
  localparam logic [QW-1:0] RND =
    (ROUND != 0 && SHIFT > 0) ? (QW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

  logic [QW-1:0] ext;
  logic [QW-1:0] q;

  // Round, shift, then clamp anything above the output range to all-ones.
  always_comb begin
    ext = QW'(sum) + RND;
    q   = ext >> SHIFT;
    sat = (q >> OUT_WIDTH) != '0;
    pix = sat ? '1 : q[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/psum_stream_accumulator.sv
// Accumulates ACC_COUNT partial-sum beats per pixel, requantises, and streams
// pixels out with tlast every ROW_LEN pixels.
//
// Handshake: both streams are AXI-Stream. A transfer happens on a clock edge
// where valid && ready are both high. Once m_axis_tvalid is raised, data and
// tlast hold until the transfer. s_axis_tready only drops for the final beat
// of a pixel while an unaccepted pixel still occupies the output register.
module psum_stream_accumulator
  import psum_stream_accumulator_pkg::*;
#(
  parameter int IN_WIDTH  = 18,
  parameter int ACC_COUNT = 3,
  parameter int SHIFT     = 8,
  parameter int ROUND     = 1,
  parameter int OUT_WIDTH = 8,
  parameter int ROW_LEN   = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic                 sat_flag
);

  localparam int ACC_W = acc_width(IN_WIDTH, ACC_COUNT);
  localparam int BW    = cnt_width(ACC_COUNT);
  localparam int CW    = cnt_width(ROW_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(ACC_COUNT - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(ROW_LEN - 1);

  logic [BW-1:0]        beat_cnt;
  logic [CW-1:0]        col_cnt;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     sum;
  logic                 last_beat;
  logic                 accept;
  logic                 final_accept;
  logic [OUT_WIDTH-1:0] pix;
  logic                 pix_sat;

  assign last_beat     = (beat_cnt == LAST_BEAT);
  assign s_axis_tready = !last_beat || !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign final_accept  = accept && last_beat;

  // The first beat of a pixel starts from zero; with ACC_COUNT==1 every beat
  // is both first and final, so this also covers the single-beat case.
  assign sum = ((beat_cnt == '0) ? '0 : acc) + ACC_W'(s_axis_tdata);

  requant_sat #(
    .ACC_W     (ACC_W),
    .SHIFT     (SHIFT),
    .ROUND     (ROUND),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_requant (
    .sum (sum),
    .pix (pix),
    .sat (pix_sat)
  );

  // Beat counter, running sum and output column counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      beat_cnt <= '0;
      col_cnt  <= '0;
      acc      <= '0;
    end else if (accept) begin
      if (last_beat) begin
        beat_cnt <= '0;
        col_cnt  <= (col_cnt == LAST_COL) ? '0 : col_cnt + 1'b1;
      end else begin
        acc      <= sum;
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // Output register: loads on a final beat (even while the previous pixel is
  // being taken), otherwise clears valid once downstream accepts.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      sat_flag      <= 1'b0;
    end else if (final_accept) begin
      m_axis_tdata  <= pix;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= (col_cnt == LAST_COL);
      if (pix_sat) sat_flag <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psum_stream_accumulator.sv
// Directed bench for psum_stream_accumulator (ACC_COUNT=3, SHIFT=8, OUT_WIDTH=8,
// ROW_LEN=4). u_dut rounds, u_trunc truncates.
module tb_psum_stream_accumulator;

  localparam int IN_W  = 18;
  localparam int OUT_W = 8;
  localparam int ROW   = 4;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [IN_W-1:0]  s_tdata;
  logic             s_tvalid;
  logic             s_tready;
  logic [OUT_W-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready;
  logic             sat;

  logic [IN_W-1:0]  t_s_tdata;
  logic             t_s_tvalid;
  logic             t_s_tready;
  logic [OUT_W-1:0] t_m_tdata;
  logic             t_m_tvalid;
  logic             t_m_tlast;
  logic             t_m_tready;
  logic             t_sat;

  psum_stream_accumulator #(
    .IN_WIDTH(IN_W), .ACC_COUNT(3), .SHIFT(8), .ROUND(1), .OUT_WIDTH(OUT_W), .ROW_LEN(ROW)
  ) u_dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready), .sat_flag(sat)
  );

  psum_stream_accumulator #(
    .IN_WIDTH(IN_W), .ACC_COUNT(3), .SHIFT(8), .ROUND(0), .OUT_WIDTH(OUT_W), .ROW_LEN(ROW)
  ) u_trunc (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(t_s_tdata), .s_axis_tvalid(t_s_tvalid), .s_axis_tready(t_s_tready),
    .m_axis_tdata(t_m_tdata), .m_axis_tvalid(t_m_tvalid), .m_axis_tlast(t_m_tlast),
    .m_axis_tready(t_m_tready), .sat_flag(t_sat)
  );

  // ---------------- scoreboard ----------------
  logic [OUT_W:0] exp_q[$];
  logic [OUT_W:0] exp_t_q[$];
  logic [OUT_W:0] mon_e;
  logic [OUT_W:0] mon_t_e;
  int n_tests = 0;
  int n_fail  = 0;
  int col     = 0;
  int t_col   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every pixel transfer on u_dut is popped and compared.
  always @(negedge clk) begin
    if (rstn && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pixel: got data %0d with nothing expected", m_tdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("pixel_data", 32'(m_tdata), 32'(mon_e[OUT_W-1:0]));
        check("pixel_tlast", 32'(m_tlast), 32'(mon_e[OUT_W]));
      end
    end
  end

  // Monitor for the truncating instance.
  always @(negedge clk) begin
    if (rstn && t_m_tvalid && t_m_tready) begin
      if (exp_t_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_trunc_pixel: got data %0d with nothing expected", t_m_tdata);
      end else begin
        mon_t_e = exp_t_q.pop_front();
        check("trunc_pixel_data", 32'(t_m_tdata), 32'(mon_t_e[OUT_W-1:0]));
        check("trunc_pixel_tlast", 32'(t_m_tlast), 32'(mon_t_e[OUT_W]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one beat and returns #1 after the edge that accepted it; valid stays
  // high so back-to-back calls stream without bubbles.
  task automatic beat(input logic [IN_W-1:0] d);
    int w;
    w = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    @(negedge clk);
    while (!s_tready && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (!s_tready) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_accept_timeout: s_tready got 0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic t_beat(input logic [IN_W-1:0] d);
    int w;
    w = 0;
    t_s_tvalid = 1'b1;
    t_s_tdata  = d;
    @(negedge clk);
    while (!t_s_tready && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (!t_s_tready) begin
      n_tests++;
      n_fail++;
      $display("FAIL trunc_beat_accept_timeout: t_s_tready got 0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_tvalid   = 1'b0;
    s_tdata    = '0;
    t_s_tvalid = 1'b0;
    t_s_tdata  = '0;
  endtask

  task automatic push_exp(input logic [OUT_W-1:0] e);
    exp_q.push_back({(col == ROW - 1), e});
    col = (col + 1) % ROW;
  endtask

  task automatic pixel(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                       input logic [IN_W-1:0] c, input logic [OUT_W-1:0] e);
    push_exp(e);
    beat(a);
    beat(b);
    beat(c);
  endtask

  task automatic t_pixel(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                         input logic [IN_W-1:0] c, input logic [OUT_W-1:0] e);
    exp_t_q.push_back({(t_col == ROW - 1), e});
    t_col = (t_col + 1) % ROW;
    t_beat(a);
    t_beat(b);
    t_beat(c);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || exp_t_q.size() != 0) && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (exp_q.size() != 0 || exp_t_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d/%0d pixels outstanding expected 0",
               exp_q.size(), exp_t_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn  = 1'b1;
    col   = 0;
    t_col = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    m_tready   = 1'b1;
    t_m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_m_tvalid", 32'(m_tvalid), 0);
    check("rst_m_tdata", 32'(m_tdata), 0);
    check("rst_m_tlast", 32'(m_tlast), 0);
    check("rst_sat_flag", 32'(sat), 0);
    check("rst_s_tready", 32'(s_tready), 1);
    @(posedge clk);
    #1;

    // 1: 256+512+768=1536, +128 -> 1664 >> 8 = 6; valid the cycle after beat 3
    pixel(18'd256, 18'd512, 18'd768, 8'd6);
    idle();
    @(negedge clk);
    check("t1_valid_latency", 32'(m_tvalid), 1);
    check("t1_sat_flag", 32'(sat), 0);
    drain();

    // 2: 3*0x3FFFF=786429, +128 >> 8 = 3072 -> saturate to 255; flag sticks
    pixel(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 8'd255);
    idle();
    drain();
    check("t2_sat_set", 32'(sat), 1);
    pixel(18'd256, 18'd256, 18'd256, 8'd3);   // 896 >> 8 = 3
    idle();
    drain();
    check("t2_sat_sticky", 32'(sat), 1);

    // 3: rounding vs truncation
    pixel(18'd128, 18'd0, 18'd0, 8'd1);       // (128+128)>>8 = 1
    pixel(18'd127, 18'd0, 18'd0, 8'd0);       // (127+128)>>8 = 0
    pixel(18'd200, 18'd200, 18'd0, 8'd2);     // (400+128)>>8 = 2
    idle();
    t_pixel(18'd128, 18'd0, 18'd0, 8'd0);     // 128>>8 = 0
    t_pixel(18'd200, 18'd200, 18'd0, 8'd1);   // 400>>8 = 1
    t_pixel(18'd255, 18'd255, 18'd255, 8'd2); // 765>>8 = 2
    t_pixel(18'd0, 18'd0, 18'd1023, 8'd3);    // 1023>>8 = 3, 4th pixel -> tlast
    idle();
    drain();

    // 4: continuous stream, 12 beats in 12 cycles, tlast every 4th pixel
    do_reset();
    check("t4_sat_cleared", 32'(sat), 0);
    begin
      int c0;
      int c1;
      c0 = cyc;
      for (int i = 0; i < 4; i++) pixel(18'd256, 18'd256, 18'd256, 8'd3);
      c1 = cyc;
      check("t4_throughput_cycles", 32'(c1 - c0), 12);
      for (int i = 0; i < 8; i++) pixel(18'd256, 18'd256, 18'd256, 8'd3);
    end
    idle();
    drain();

    // 5: output held, final beat stalls, then reload on release
    m_tready = 1'b0;
    pixel(18'd256, 18'd256, 18'd256, 8'd3);   // pixel A held
    idle();
    @(negedge clk);
    check("t5_held_valid", 32'(m_tvalid), 1);
    @(posedge clk);
    #1;
    push_exp(8'd6);                           // pixel B: 1536+128 >> 8 = 6
    beat(18'd512);
    beat(18'd512);
    s_tvalid = 1'b1;
    s_tdata  = 18'd512;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_stall_s_tready", 32'(s_tready), 0);
      check("t5_stable_tdata", 32'(m_tdata), 3);
      check("t5_stable_tvalid", 32'(m_tvalid), 1);
      check("t5_stable_tlast", 32'(m_tlast), 0);
    end
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    @(negedge clk);
    check("t5_release_s_tready", 32'(s_tready), 1);
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    check("t5_reload_valid", 32'(m_tvalid), 1);
    check("t5_reload_data", 32'(m_tdata), 6);
    drain();

    // 6: reset mid-pixel discards partial sum and restarts the column count
    beat(18'd256);
    beat(18'd256);
    idle();
    do_reset();
    @(negedge clk);
    check("t6_rst_m_tvalid", 32'(m_tvalid), 0);
    check("t6_rst_s_tready", 32'(s_tready), 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) pixel(18'd256, 18'd256, 18'd256, 8'd3);
    idle();
    drain();

    check("final_queue_empty", 32'(exp_q.size()), 0);
    check("final_trunc_queue_empty", 32'(exp_t_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
